// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch (I) and load/store (D) requesters.
// Latency: grant in IDLE -> REQ next cycle -> WAIT; requester sees data 3 cycles after its request at the earliest.
// Backpressure: m_mem_rdy=0 holds REQ and m_valid=0 holds WAIT, with the registered m_* outputs held stable.
module mem_arbiter #(
  parameter int nbits       = 32,
  parameter int MAX_D_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  // fetch side
  input  logic             i_proc_req,
  input  logic [nbits-1:0] i_addr,
  input  logic             i_flush,
  output logic             i_mem_rdy,
  output logic             i_valid,
  output logic [nbits-1:0] i_rdata,
  // load/store side
  input  logic             d_proc_req,
  input  logic             d_we,
  input  logic [nbits-1:0] d_addr,
  input  logic [nbits-1:0] d_wdata,
  output logic             d_mem_rdy,
  output logic             d_valid,
  output logic [nbits-1:0] d_rdata,
  // memory side
  output logic             m_proc_req,
  output logic             m_we,
  output logic [nbits-1:0] m_addr,
  output logic [nbits-1:0] m_wdata,
  input  logic             m_mem_rdy,
  input  logic             m_valid,
  input  logic [nbits-1:0] m_rdata,
  // status
  output logic             owner,
  output logic             busy,
  output logic             protocol_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [3:0] MAX_B = 4'(MAX_D_BURST);

  state_t     state;
  state_t     state_nx;
  logic [3:0] d_streak;
  logic       drop;

  logic       hs;        // memory accepts the request this cycle
  logic       resp;      // memory response for the current transaction
  logic       arb_en;    // cycle in which a new grant may be issued
  logic       d_blocked; // D has used up its burst while I waits
  logic       grant_d;
  logic       grant_i;
  logic       i_kill;    // I-side pulses are hidden for a flushed fetch

  assign hs        = (state == REQ)  && m_mem_rdy;
  assign resp      = (state == WAIT) && m_valid;
  assign arb_en    = (state == IDLE) || resp;
  assign d_blocked = i_proc_req && (d_streak == MAX_B);
  assign grant_d   = arb_en && d_proc_req && !d_blocked;
  assign grant_i   = arb_en && !grant_d && i_proc_req;

  // A flush in the same cycle as a pulse suppresses it, as does an earlier flush.
  assign i_kill    = drop || i_flush;

  assign m_proc_req = (state == REQ);
  assign busy       = (state != IDLE);

  assign i_mem_rdy  = hs && !owner && !i_kill;
  assign d_mem_rdy  = hs && owner;
  assign i_valid    = resp && !owner && !i_kill;
  assign d_valid    = resp && owner;
  assign i_rdata    = i_valid ? m_rdata : '0;
  assign d_rdata    = d_valid ? m_rdata : '0;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: REQ waits for acceptance, WAIT for the response, then re-arbitrate.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (grant_d || grant_i) begin
          state_nx = REQ;
        end
      end
      REQ: begin
        if (m_mem_rdy) begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (m_valid) begin
          state_nx = (grant_d || grant_i) ? REQ : IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Capture the winning request; these registers only move on a grant so they stay stable across stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else if (grant_d) begin
      owner   <= 1'b1;
      m_we    <= d_we;
      m_addr  <= d_addr;
      m_wdata <= d_wdata;
    end else if (grant_i) begin
      owner   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= i_addr;
      m_wdata <= '0;
    end
  end

  // Count D grants taken while I is waiting; an I grant or an uncontended D grant resets the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_streak <= 4'd0;
    end else if (grant_d) begin
      if (!i_proc_req) begin
        d_streak <= 4'd0;
      end else if (d_streak < MAX_B) begin
        d_streak <= d_streak + 4'd1;
      end
    end else if (grant_i) begin
      d_streak <= 4'd0;
    end
  end

  // Mark an in-flight fetch as flushed; the mark lasts until its response retires it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop <= 1'b0;
    end else if (resp) begin
      drop <= 1'b0;
    end else if ((state != IDLE) && !owner && i_flush) begin
      drop <= 1'b1;
    end
  end

  // Sticky flag for a memory response arriving when none is outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      protocol_err <= 1'b0;
    end else if (m_valid && (state != WAIT)) begin
      protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios followed by randomized traffic.
// Every cycle, all outputs are compared against a transaction-record reference model.
// Requesters and memory are modelled in the bench and obey the handshake rules.
module tb_mem_arbiter;

  localparam int NB   = 32;
  localparam int MAXB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_proc_req, i_flush, i_mem_rdy, i_valid;
  logic [NB-1:0] i_addr, i_rdata;
  logic          d_proc_req, d_we, d_mem_rdy, d_valid;
  logic [NB-1:0] d_addr, d_wdata, d_rdata;
  logic          m_proc_req, m_we, m_mem_rdy, m_valid;
  logic [NB-1:0] m_addr, m_wdata, m_rdata;
  logic          owner, busy, protocol_err;

  mem_arbiter #(.nbits(NB), .MAX_D_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .i_proc_req(i_proc_req), .i_addr(i_addr), .i_flush(i_flush),
    .i_mem_rdy(i_mem_rdy), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_proc_req(d_proc_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_mem_rdy(d_mem_rdy), .d_valid(d_valid), .d_rdata(d_rdata),
    .m_proc_req(m_proc_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_mem_rdy(m_mem_rdy), .m_valid(m_valid), .m_rdata(m_rdata),
    .owner(owner), .busy(busy), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: the transaction currently owning the memory port.
  bit            t_act, t_acc, t_own, t_we, t_drop, perr;
  logic [NB-1:0] t_addr, t_wdata;
  int            streak;
  // Expected pulses for the current cycle.
  bit            e_hs, e_resp, e_imrdy, e_dmrdy, e_ivld, e_dvld;
  // Bench requester state.
  bit            i_pend, i_out, d_pend, d_out;
  int            nr, nv;
  logic [5:0]    seq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    t_act = 0; t_acc = 0; t_own = 0; t_we = 0; t_drop = 0; perr = 0;
    t_addr = '0; t_wdata = '0; streak = 0;
  endtask

  // Called at a negedge once inputs are driven: compute expectations and compare.
  task automatic settle();
    #1;
    e_hs    = t_act && !t_acc && m_mem_rdy;
    e_resp  = t_act && t_acc && m_valid;
    e_imrdy = e_hs && !t_own && !t_drop && !i_flush;
    e_dmrdy = e_hs && t_own;
    e_ivld  = e_resp && !t_own && !t_drop && !i_flush;
    e_dvld  = e_resp && t_own;
    check("busy", busy, t_act);
    check("m_proc_req", m_proc_req, t_act && !t_acc);
    check("owner", owner, t_own);
    check("m_we", m_we, t_we);
    check("m_addr", m_addr, t_addr);
    check("m_wdata", m_wdata, t_wdata);
    check("i_mem_rdy", i_mem_rdy, e_imrdy);
    check("d_mem_rdy", d_mem_rdy, e_dmrdy);
    check("i_valid", i_valid, e_ivld);
    check("d_valid", d_valid, e_dvld);
    check("i_rdata", i_rdata, e_ivld ? m_rdata : 32'h0);
    check("d_rdata", d_rdata, e_dvld ? m_rdata : 32'h0);
    check("protocol_err", protocol_err, perr);
  endtask

  // Apply the rules for the coming clock edge, then move to the next negedge.
  task automatic advance();
    if (!rst) begin
      if (m_valid && !(t_act && t_acc)) perr = 1;
      if (t_act && !t_own && i_flush) t_drop = 1;
      if (e_hs) t_acc = 1;
      if (!t_act || e_resp) begin
        t_drop = 0;
        if (d_proc_req && !(i_proc_req && streak == MAXB)) begin
          t_act = 1; t_acc = 0; t_own = 1;
          t_we = d_we; t_addr = d_addr; t_wdata = d_wdata;
          streak = i_proc_req ? ((streak + 1 > MAXB) ? MAXB : streak + 1) : 0;
        end else if (i_proc_req) begin
          t_act = 1; t_acc = 0; t_own = 0;
          t_we = 0; t_addr = i_addr; t_wdata = '0;
          streak = 0;
        end else begin
          t_act = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic drive_random(input bit allow_new);
    if (allow_new && !i_pend && !i_out && $urandom_range(0, 2) == 0) begin
      i_pend = 1; i_addr = $urandom;
    end
    if (allow_new && !d_pend && !d_out && $urandom_range(0, 2) == 0) begin
      d_pend = 1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
    end
    i_flush = 1'b0;
    if (allow_new) begin
      if (t_act && !t_own) begin
        if ($urandom_range(0, 9) == 0) begin
          // Branch redirect: the old fetch is abandoned, a new one is requested.
          i_flush = 1'b1; i_pend = 1; i_out = 0; i_addr = $urandom;
        end
      end else if ($urandom_range(0, 19) == 0) begin
        i_flush = 1'b1;
      end
    end
    i_proc_req = i_pend;
    d_proc_req = d_pend;
    m_mem_rdy  = 1'($urandom_range(0, 1));
    m_valid    = (t_act && t_acc) ? 1'($urandom_range(0, 1)) : 1'b0;
    m_rdata    = $urandom;
  endtask

  task automatic update_reqs();
    if (e_imrdy) begin i_pend = 0; i_out = 1; end
    if (e_ivld)  i_out = 0;
    if (e_dmrdy) begin d_pend = 0; d_out = 1; end
    if (e_dvld)  d_out = 0;
  endtask

  initial begin
    rst = 1'b1;
    i_proc_req = 0; i_addr = '0; i_flush = 0;
    d_proc_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    m_mem_rdy = 0; m_valid = 0; m_rdata = '0;
    i_pend = 0; i_out = 0; d_pend = 0; d_out = 0;
    model_reset();

    // Reset state.
    @(negedge clk);
    step();
    rst = 1'b0;
    step();

    // Single I read.
    i_proc_req = 1; i_addr = 32'h100; step();
    m_mem_rdy = 1; settle(); check("t1_imrdy", i_mem_rdy, 1); advance();
    i_proc_req = 0; m_mem_rdy = 0; m_valid = 1; m_rdata = 32'hDEADBEEF;
    settle(); check("t1_ivalid", i_valid, 1); check("t1_rdata", i_rdata, 32'hDEADBEEF); advance();
    m_valid = 0; m_rdata = '0; settle(); check("t1_idle", busy, 0); advance();

    // Contention: D store wins, I follows on the D completion cycle.
    i_proc_req = 1; i_addr = 32'h180;
    d_proc_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'h55; step();
    m_mem_rdy = 1; settle();
    check("t2_owner", owner, 1); check("t2_we", m_we, 1); check("t2_wdata", m_wdata, 32'h55);
    check("t2_dmrdy", d_mem_rdy, 1); advance();
    d_proc_req = 0; m_mem_rdy = 0; m_valid = 1; settle(); check("t2_dvalid", d_valid, 1); advance();
    m_valid = 0; m_mem_rdy = 1; settle();
    check("t2_i_owner", owner, 0); check("t2_i_addr", m_addr, 32'h180); check("t2_imrdy", i_mem_rdy, 1); advance();
    i_proc_req = 0; m_mem_rdy = 0; m_valid = 1; m_rdata = 32'hA5A5; step();
    m_valid = 0; d_we = 0; d_wdata = '0; step();

    // Starvation guard: both held high, expect D,D,D,D,I,D.
    seq = 6'b101111;
    i_proc_req = 1; d_proc_req = 1; i_addr = 32'h600; d_addr = 32'h700; step();
    for (int k = 0; k < 6; k++) begin
      m_mem_rdy = 1; m_valid = 0; settle();
      check($sformatf("t3_grant%0d", k), owner, seq[k]); advance();
      m_mem_rdy = 0; m_valid = 1;
      if (k == 5) begin i_proc_req = 0; d_proc_req = 0; end
      step();
    end
    m_valid = 0; step();

    // Flush of a fetch in WAIT, then the redirected fetch.
    i_proc_req = 1; i_addr = 32'h300; step();
    m_mem_rdy = 1; settle(); check("t4_imrdy0", i_mem_rdy, 1); advance();
    m_mem_rdy = 0; i_flush = 1; i_proc_req = 1; i_addr = 32'h400; step();
    i_flush = 0; step();
    m_valid = 1; m_rdata = 32'h1234; settle();
    check("t4_drop_ivalid", i_valid, 0); check("t4_drop_rdata", i_rdata, 0); advance();
    m_valid = 0; m_mem_rdy = 1; settle();
    check("t4_new_addr", m_addr, 32'h400); check("t4_imrdy1", i_mem_rdy, 1); advance();
    i_proc_req = 0; m_mem_rdy = 0; m_valid = 1; m_rdata = 32'h5678; settle();
    check("t4_ivalid", i_valid, 1); check("t4_rdata", i_rdata, 32'h5678); advance();
    m_valid = 0; step();

    // Memory stalls on both phases.
    nr = 0; nv = 0;
    d_proc_req = 1; d_we = 0; d_addr = 32'h500; step();
    for (int k = 0; k < 5; k++) begin
      m_mem_rdy = 0; settle();
      check("t5_mreq", m_proc_req, 1); check("t5_addr", m_addr, 32'h500); check("t5_owner", owner, 1);
      nr += int'(d_mem_rdy); nv += int'(d_valid); advance();
    end
    m_mem_rdy = 1; settle(); nr += int'(d_mem_rdy); nv += int'(d_valid); advance();
    d_proc_req = 0; m_mem_rdy = 0;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("t5_waddr", m_addr, 32'h500); check("t5_wowner", owner, 1);
      nr += int'(d_mem_rdy); nv += int'(d_valid); advance();
    end
    m_valid = 1; m_rdata = 32'hCAFE; settle(); nr += int'(d_mem_rdy); nv += int'(d_valid); advance();
    m_valid = 0; step();
    check("t5_nrdy", nr, 1); check("t5_nvld", nv, 1);

    // Protocol error, then asynchronous reset during REQ.
    m_valid = 1; step();
    m_valid = 0; settle(); check("t6_perr", protocol_err, 1); advance();
    step();
    i_proc_req = 1; i_addr = 32'h800; step();
    m_mem_rdy = 1; settle();
    #2; rst = 1'b1; #1;
    check("t6_rst_mreq", m_proc_req, 0); check("t6_rst_busy", busy, 0);
    check("t6_rst_imrdy", i_mem_rdy, 0); check("t6_rst_perr", protocol_err, 0);
    check("t6_rst_addr", m_addr, 0);
    model_reset();
    i_proc_req = 0; m_mem_rdy = 0; i_addr = '0;
    @(negedge clk);
    rst = 1'b0;
    step();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      drive_random(1'b1);
      settle();
      update_reqs();
      advance();
    end
    for (int c = 0; c < 300 && (t_act || i_pend || d_pend || i_out || d_out); c++) begin
      drive_random(1'b0);
      settle();
      update_reqs();
      advance();
    end
    check("drain_busy", busy, 0);
    check("drain_reqs", {28'h0, i_pend, d_pend, i_out, d_out}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port to one-port memory arbiter/sequencer for the pipelined RISC-V core. It shares a single memory port between the fetch unit's instruction requests (I-side) and the memory stage's load/store requests (D-side), and sequences each transaction through address and response phases. D-side has fixed priority, with a starvation guard for I-side. Pipeline flushes silently kill in-flight fetches.

## Interface
- nbits, default 32: address/data width.
- MAX_D_BURST, default 4: consecutive D grants allowed while I is pending before I is forced; range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- i_proc_req  in  1  fetch request; held until i_mem_rdy.
- i_addr  in  nbits  fetch address.
- i_flush  in  1  pipeline flush (branch taken).
- i_mem_rdy  out  1  fetch request accepted (1-cycle pulse).
- i_valid  out  1  fetch data valid (1-cycle pulse).
- i_rdata  out  nbits  fetch data; 0 when i_valid=0.
- d_proc_req  in  1  load/store request; held until d_mem_rdy.
- d_we  in  1  1 = store.
- d_addr  in  nbits  data address.
- d_wdata  in  nbits  store data.
- d_mem_rdy  out  1  data request accepted (pulse).
- d_valid  out  1  load data / store ack (pulse).
- d_rdata  out  nbits  load data; 0 when d_valid=0.
- m_proc_req  out  1  request to memory.
- m_we  out  1  write enable to memory.
- m_addr  out  nbits  registered address.
- m_wdata  out  nbits  registered write data.
- m_mem_rdy  in  1  memory accepts request.
- m_valid  in  1  memory response valid (reads and writes).
- m_rdata  in  nbits  memory read data.
- owner  out  1  0 = I-side, 1 = D-side owns current transaction.
- busy  out  1  state != IDLE.
- protocol_err  out  1  sticky: m_valid seen outside WAIT.

## Operation
- FSM states: IDLE, REQ, WAIT.
- Arbitration, evaluated in IDLE and on the WAIT completion cycle: D wins if d_proc_req=1, unless i_proc_req=1 and d_streak=MAX_D_BURST, in which case I wins. Otherwise I wins if i_proc_req=1.
- On a grant, register owner, m_addr, m_we (0 for I), and m_wdata (0 for I). Next state is REQ.
- d_streak (4 bits):
  - increments on a D grant while i_proc_req=1;
  - clears on an I grant;
  - clears on a D grant while i_proc_req=0;
  - saturates at MAX_D_BURST.
- REQ: m_proc_req=1 and is never withdrawn. When m_mem_rdy=1, the owner's x_mem_rdy pulses (combinational) and the next state is WAIT.
- WAIT: when m_valid=1, the owner's x_valid=1 and x_rdata=m_rdata (combinational). That cycle re-arbitrates: next state is REQ with a new grant, or IDLE if there is no request.
- The non-owner's mem_rdy/valid are always 0. A requester whose x_mem_rdy has pulsed must not re-raise its request until its x_valid arrives.
- Flush:
  - i_flush=1 with owner=I in REQ or WAIT sets the drop flag.
  - With drop set, i_mem_rdy and i_valid are suppressed. The memory handshake still completes normally, and drop clears on m_valid.
  - i_flush in IDLE, or with owner=D, has no effect.
  - The fetch unit keeps i_proc_req high with its redirected address. That request arbitrates again after the dropped transaction completes.
- m_valid in IDLE or REQ is ignored for data routing and sets protocol_err. protocol_err is cleared only by rst.

## Timing
- Reset (async): state=IDLE, owner=0, d_streak=0, drop=0, protocol_err=0, m_proc_req=0, m_we=0, m_addr=0, m_wdata=0. All x_mem_rdy, x_valid and x_rdata outputs are 0.
- Latency: request sampled in IDLE at edge N, so m_proc_req=1 during cycle N+1. If m_mem_rdy=1 in that cycle, WAIT starts at N+2. With m_valid=1 at N+2, the requester sees x_valid in cycle N+2, a 3-cycle minimum.
- Back-to-back throughput: one transaction per 2 cycles (REQ, WAIT, REQ, ...) with a zero-wait memory.
- Memory stalls extend REQ (m_mem_rdy=0) or WAIT (m_valid=0) indefinitely. Registered m_* outputs stay stable.
- Simultaneous events:
  - i_flush in the same cycle as m_valid for an I transaction: that response is dropped.
  - i_flush in the same cycle as i_mem_rdy would pulse: the pulse is suppressed.
- rst mid-transaction aborts immediately to IDLE with no completion pulses. Memory-side cleanup is the system's responsibility.

## Test plan
- Single I read: i_addr=0x100, memory accepts on the first REQ cycle and returns 0xDEADBEEF the next cycle. Expect i_mem_rdy and then i_valid in consecutive cycles, i_rdata=0xDEADBEEF, busy low afterwards.
- Contention: i_proc_req and d_proc_req rise together (store 0x200 <- 0x55). Expect owner=1, m_we=1, m_wdata=0x55 first, then the I transaction starts on the D completion cycle.
- Starvation guard (MAX_D_BURST=4): d_proc_req and i_proc_req held high continuously. Expect grant sequence D,D,D,D,I,D,...
- Flush: I read to 0x300 in WAIT, pulse i_flush, memory returns 0x1234 two cycles later. Expect no i_valid and no i_mem_rdy, then a new I transaction to the redirected 0x400 delivering its data.
- Memory stalls: m_mem_rdy held low 5 cycles, then m_valid delayed 3 cycles. Expect m_proc_req, m_addr and owner stable throughout, and exactly one x_mem_rdy and one x_valid pulse.
- Error/reset: m_valid pulsed in IDLE sets protocol_err, which stays high. Then assert rst during REQ: all outputs are 0 asynchronously, state=IDLE and protocol_err=0.
